// File: rtl/wbu_pkg.sv
// Shared types and constants for the write-back unit and load extension logic.
package wbu_pkg;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wbu_state_e;
endpackage

// File: rtl/wbu_load_extend.sv
// Picks the byte/half/word out of an aligned memory word and sign/zero extends it.
module wbu_load_extend
  import wbu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ext
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{off, 3'b000} +: 8];
  // Halfword lanes are selected by off[1] only; off[0] is ignored.
  assign half_v = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    ext = rdata;
    unique case (funct3)
      F3_LB:   ext = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      F3_LBU:  ext = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      F3_LH:   ext = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      F3_LHU:  ext = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: ext = rdata;  // LW and undefined encodings
    endcase
  end
endmodule

// File: rtl/wbu.sv
// Write-back unit: retires ALU results in one cycle, loads after the memory response.
module wbu
  import wbu_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_AW,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit,
  output logic                  busy
);
  wbu_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] ld_rd;
  logic                  ld_wen;
  logic [2:0]            ld_f3;
  logic [1:0]            ld_off;
  logic [DATA_WIDTH-1:0] ld_ext;

  logic acc, ld_done;
  assign acc     = (state == IDLE) && in_valid;
  assign ld_done = (state == WAIT_MEM) && mem_rvalid;

  wbu_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
    .funct3 (ld_f3),
    .off    (ld_off),
    .rdata  (mem_rdata),
    .ext    (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (acc && in_is_load) state_nxt = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid)        state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state == WAIT_MEM);
  end

  // Write port and commit are pulses; address/data hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      commit   <= 1'b0;
      ld_rd    <= '0;
      ld_wen   <= 1'b0;
      ld_f3    <= '0;
      ld_off   <= '0;
    end else begin
      rf_wen <= 1'b0;
      commit <= 1'b0;
      if (acc && !in_is_load) begin
        rf_wen   <= in_rd_wen && (in_rd != '0);
        rf_waddr <= in_rd;
        rf_wdata <= in_result;
        commit   <= 1'b1;
      end else if (acc) begin
        ld_rd  <= in_rd;
        ld_wen <= in_rd_wen;
        ld_f3  <= in_funct3;
        ld_off <= in_result[1:0];
      end else if (ld_done) begin
        rf_wen   <= ld_wen && (ld_rd != '0);
        rf_waddr <= ld_rd;
        rf_wdata <= ld_ext;
        commit   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wbu.sv
// Directed + randomized bench for wbu with a behavioural load-extension model.
module tb_wbu;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wbu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_result(in_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit(commit), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: shift the selected lane down, mask, then extend by adding the high ones.
  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (w >> (off * 8)) & 32'hFF;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        v = (w >> ((off / 2) * 16)) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_is_load = 0; in_rd = 0; in_rd_wen = 0; in_funct3 = 0; in_result = 0;
  endtask

  // Drives one ALU instruction; in_valid is left high so callers can chain.
  task automatic alu(input logic [4:0] rd, input logic wen, input logic [31:0] val);
    chk("alu_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1; in_is_load = 0; in_rd = rd; in_rd_wen = wen; in_result = val; in_funct3 = 0;
    tick();
    chk("alu_wen", {31'd0, rf_wen}, {31'd0, wen && (rd != 0)});
    chk("alu_commit", {31'd0, commit}, 32'd1);
    if (wen && rd != 0) begin
      chk("alu_waddr", {27'd0, rf_waddr}, {27'd0, rd});
      chk("alu_wdata", rf_wdata, val);
    end
  endtask

  task automatic load(input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] word, input int waits);
    logic [31:0] exp;
    chk("ld_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1; in_is_load = 1; in_rd = rd; in_rd_wen = wen; in_funct3 = f3; in_result = addr;
    tick();
    idle_in();
    chk("ld_acc_wen", {31'd0, rf_wen}, 32'd0);
    chk("ld_acc_commit", {31'd0, commit}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      mem_rdata = $urandom;
      chk("ld_busy", {31'd0, busy}, 32'd1);
      chk("ld_nready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("ld_wait_wen", {31'd0, rf_wen}, 32'd0);
      chk("ld_wait_commit", {31'd0, commit}, 32'd0);
    end
    mem_rvalid = 1; mem_rdata = word;
    tick();
    mem_rvalid = 0; mem_rdata = $urandom;
    exp = ref_ext(f3, int'(addr[1:0]), word);
    chk("ld_wen", {31'd0, rf_wen}, {31'd0, wen && (rd != 0)});
    chk("ld_commit", {31'd0, commit}, 32'd1);
    chk("ld_busy_done", {31'd0, busy}, 32'd0);
    if (wen && rd != 0) begin
      chk("ld_waddr", {27'd0, rf_waddr}, {27'd0, rd});
      chk("ld_wdata", rf_wdata, exp);
    end
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    idle_in();
    mem_rvalid = 0; mem_rdata = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_commit", {31'd0, commit}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);

    // ALU write, then pulse drops
    alu(5'd5, 1'b1, 32'h1234_5678);
    idle_in();
    tick();
    chk("alu_wen_drop", {31'd0, rf_wen}, 32'd0);
    chk("alu_commit_drop", {31'd0, commit}, 32'd0);

    // Back-to-back
    alu(5'd1, 1'b1, 32'hA);
    alu(5'd2, 1'b1, 32'hB);
    idle_in();
    tick();

    // rd == 0
    alu(5'd0, 1'b1, 32'hDEAD_BEEF);
    idle_in();
    tick();

    // Directed loads
    load(5'd7, 1'b1, 3'b000, 32'h0000_1003, 32'h80FF_0000, 4);
    load(5'd8, 1'b1, 3'b101, 32'h0000_2002, 32'h8001_0000, 1);
    load(5'd9, 1'b1, 3'b001, 32'h0000_2002, 32'h8001_0000, 0);
    load(5'd10, 1'b1, 3'b010, 32'h0000_2000, 32'h8001_0000, 2);
    chk("lhu_prev", rf_wdata, 32'h8001_0000);

    // mem_rvalid in IDLE is ignored
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 0;
    chk("stale_idle_wen", {31'd0, rf_wen}, 32'd0);
    chk("stale_idle_commit", {31'd0, commit}, 32'd0);
    chk("stale_idle_busy", {31'd0, busy}, 32'd0);

    // Reset while waiting drops the load
    in_valid = 1; in_is_load = 1; in_rd = 5'd3; in_rd_wen = 1; in_funct3 = 3'b010; in_result = 32'h40;
    tick();
    idle_in();
    chk("rstw_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    tick();
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_rvalid = 0;
    chk("rstw_wen", {31'd0, rf_wen}, 32'd0);
    chk("rstw_commit", {31'd0, commit}, 32'd0);
    chk("rstw_ready", {31'd0, in_ready}, 32'd1);
    chk("rstw_busy0", {31'd0, busy}, 32'd0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      logic [4:0] rd;
      logic wen;
      rd  = 5'($urandom_range(0, 31));
      wen = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        load(rd, wen, f3s[$urandom_range(0, 7)], $urandom, $urandom, $urandom_range(0, 3));
      else
        alu(rd, wen, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        idle_in();
        tick();
        chk("rnd_idle_wen", {31'd0, rf_wen}, 32'd0);
      end
    end
    idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
